// File: rtl/boruhatti_paketleyici.sv
// Serial-to-parallel packer: collects eight N-bit samples and strobes them onto sayi1..sayi8 for the 8-operand adder.
// Latency 1 clk from accepting/flushing edge to giris_etkin; veri_hazir drops only for the one-cycle gap after a partial flush.
// Optional sticky overflow flag tasma when PAKETLEYICI_TASMA_EN is defined; no downstream backpressure.
module boruhatti_paketleyici #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] veri_giris,
    input  logic         veri_gecerli,
    output logic         veri_hazir,
    input  logic         bosalt,
    output logic [N-1:0] sayi1,
    output logic [N-1:0] sayi2,
    output logic [N-1:0] sayi3,
    output logic [N-1:0] sayi4,
    output logic [N-1:0] sayi5,
    output logic [N-1:0] sayi6,
    output logic [N-1:0] sayi7,
    output logic [N-1:0] sayi8,
    output logic         giris_etkin,
    output logic [3:0]   gecerli_adet
`ifdef PAKETLEYICI_TASMA_EN
    ,
    output logic         tasma
`endif
);

    localparam logic [0:0] TOPLA = 1'b0;
    localparam logic [0:0] ARA   = 1'b1;

    logic [0:0]   state;
    logic [2:0]   cnt;
    logic [N-1:0] slot [8];
    logic [N-1:0] lane [8];
    logic [N-1:0] pad  [8];
    logic         acc;
    logic [3:0]   k;
    logic         full;
    logic         flush_part;

    assign veri_hazir = rst_n && (state == TOPLA);
    assign acc        = veri_gecerli && veri_hazir;
    assign k          = {1'b0, cnt} + {3'b000, acc};
    assign full       = acc && (cnt == 3'd7);
    assign flush_part = bosalt && (state == TOPLA) && (k != 4'd0) && !full;

    // One lane builder serves both full and partial emits: stored slots, then the
    // sample accepted on this edge, then zero padding.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            pad[i] = '0;
            if (i < int'(cnt))
                pad[i] = slot[i];
            else if ((i == int'(cnt)) && acc)
                pad[i] = veri_giris;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= TOPLA;
            cnt          <= '0;
            giris_etkin  <= 1'b0;
            gecerli_adet <= '0;
            for (int i = 0; i < 8; i++) begin
                slot[i] <= '0;
                lane[i] <= '0;
            end
        end else begin
            giris_etkin <= 1'b0;
            if (full || flush_part) begin
                for (int i = 0; i < 8; i++)
                    lane[i] <= pad[i];
                giris_etkin  <= 1'b1;
                gecerli_adet <= k;
                cnt          <= '0;
                // Full groups stream back-to-back; only a partial flush opens a frame gap.
                if (flush_part)
                    state <= ARA;
            end else begin
                if (acc) begin
                    slot[cnt] <= veri_giris;
                    cnt       <= cnt + 3'd1;
                end
                if (state == ARA)
                    state <= TOPLA;
            end
        end
    end

`ifdef PAKETLEYICI_TASMA_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            tasma <= 1'b0;
        else if (veri_gecerli && !veri_hazir)
            tasma <= 1'b1;
    end
`endif

    assign sayi1 = lane[0];
    assign sayi2 = lane[1];
    assign sayi3 = lane[2];
    assign sayi4 = lane[3];
    assign sayi5 = lane[4];
    assign sayi6 = lane[5];
    assign sayi7 = lane[6];
    assign sayi8 = lane[7];

endmodule

// File: doc/boruhatti_paketleyici.md
Name: boruhatti_paketleyici

Overview:
- Serial-to-parallel packer directly upstream of the 8-operand pipelined adder.
- Accepts one N-bit sample per cycle over a valid/ready handshake and collects eight samples.
- Presents the group on sayi1..sayi8 with a single-cycle giris_etkin pulse, so the adder's inputs connect without glue logic.
- A flush input emits a partial group, zero-padded, at the end of a frame.

Parameters:
N, 8, sample width in bits; matches the adder's N.

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
veri_giris  input  N  incoming sample
veri_gecerli  input  1  veri_giris valid this cycle
veri_hazir  output  1  block can accept a sample this cycle
bosalt  input  1  flush request: emit collected partial group
sayi1..sayi8  output  N each  packed group (registered); sayi1 = oldest sample
giris_etkin  output  1  one-cycle strobe: sayi1..sayi8 valid; connects to adder giris_etkin
gecerli_adet  output  4  number of real samples in emitted group, 1..8

Behaviour:
- Interface: one clock, clk; asynchronous active-low reset, rst_n.
- Reset (async, rst_n=0):
  - sayi1..sayi8=0, giris_etkin=0, gecerli_adet=0.
  - Slot count=0, state=TOPLA, veri_hazir=0 while rst_n=0.
  - Any partial group is discarded.
- Accept: a sample is taken on a rising edge when veri_gecerli=1 and veri_hazir=1. It is stored in slot[count] and count increments.
- States:
  - TOPLA: veri_hazir=1.
  - ARA: veri_hazir=0; lasts exactly one cycle, then TOPLA.
- Full emit: the edge that accepts the 8th sample (count 7 -> 8) loads sayi1..sayi7 from slots 0..6 and sayi8 from veri_giris. It sets giris_etkin=1 and gecerli_adet=8, and resets count to 0. State stays TOPLA, so there is no bubble and back-to-back groups are possible every 8 cycles.
- Flush: bosalt=1 sampled in TOPLA. Let k = count after any simultaneous accept.
  - k=0: no action.
  - k=8: normal full emit; flush is absorbed, no ARA.
  - k in 1..7: emit slots 0..k-1 on sayi1..sayik, zeros on the remaining lanes. Set giris_etkin=1, gecerli_adet=k, count=0, then go to ARA for one frame-gap cycle.
- A simultaneous accept and bosalt always includes the accepted sample in the flushed group.
- bosalt in ARA is ignored.
- Output hold:
  - giris_etkin is high for exactly one cycle per emit, otherwise 0.
  - sayi1..sayi8 and gecerli_adet hold their last emitted values between emits.
- Latency: 1 clock from the accepting/flushing edge to giris_etkin high.
- Width: outputs are plain copies, no arithmetic. Zero padding makes a partial group's adder sum equal the sum of the real samples.
- No backpressure from downstream (the adder accepts every cycle).

Optional Feature:
- Macro: PAKETLEYICI_TASMA_EN.
- Defined:
  - Adds output tasma (1 bit, reset 0).
  - tasma is a sticky flag set on any edge where veri_gecerli=1 and veri_hazir=0; cleared only by rst_n.
  - The offending sample is dropped.
- Undefined: no tasma port. Samples offered while veri_hazir=0 are silently ignored, and upstream must honour veri_hazir.

Test Plan:
- Reset, then 8 consecutive valid samples 1..8 (N=8) -> one cycle after the 8th: giris_etkin=1, sayi1..sayi8=1..8, gecerli_adet=8; giris_etkin low next cycle.
- 16 back-to-back samples 0x10..0x1F -> two giris_etkin pulses 8 cycles apart; second group sayi1=0x18..sayi8=0x1F; veri_hazir never drops.
- 3 samples 0xA,0xB,0xC then bosalt -> giris_etkin=1, sayi1..3=0xA,0xB,0xC, sayi4..8=0, gecerli_adet=3; veri_hazir=0 for exactly one cycle.
- 7 samples with bosalt asserted together with the 8th sample -> full group, gecerli_adet=8, no ARA cycle; bosalt with count 0 -> no strobe.
- rst_n pulled low mid-group after 5 samples, released, then 8 new samples -> outputs zero during reset; first emit contains only the 8 new samples.
- With PAKETLEYICI_TASMA_EN: drive veri_gecerli=1 during the ARA cycle -> tasma=1 and stays 1; sample absent from the next group; cleared only by rst_n.
